// File: rtl/vote_collector.sv
// vote_collector: upstream stage of a 3-input majority voter.
// It opens a session on start and accepts one ballot per voter (A/B/C).
// Voters that have not cast by the timeout receive DEFAULT_BALLOT.
// The stable A/B/C are driven into the voter, res_in is captured, and a done pulse is raised.
// Optional feature macro: VOTE_COLLECT_TALLY_EN (pass/fail session counters).
module vote_collector #(
  parameter int   TIMEOUT        = 16,
  parameter logic DEFAULT_BALLOT = 1'b0,
  parameter int   CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ballot_valid,
  input  logic [1:0]       ballot_id,
  input  logic             ballot_val,
  output logic             ballot_ready,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             res_in,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             dup_err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    mask;     // bit i set once voter i has cast
  logic [2:0]    abc;      // abc[0]=A, abc[1]=B, abc[2]=C

  logic [2:0] id_oh;
  logic       hs, acc, dup, full, tmo;
  logic [2:0] mask_nxt, abc_nxt;

  assign A = abc[0];
  assign B = abc[1];
  assign C = abc[2];

  // Decode this cycle's handshake: accept first cast per voter, reject repeats and id 3
  always_comb begin
    id_oh    = 3'b001 << ballot_id;   // id 3 shifts out to all-zero, never matches a voter
    hs       = ballot_valid & (state == COLLECT);
    acc      = hs & (|(id_oh & ~mask));
    dup      = hs & ~acc;
    mask_nxt = mask | (acc ? id_oh : 3'b000);
    full     = &mask_nxt;
    tmo      = (timer == TLAST);
    abc_nxt  = abc;
    for (int i = 0; i < 3; i++) begin
      if (acc && id_oh[i])
        abc_nxt[i] = ballot_val;      // a ballot on the timeout cycle beats the default
      else if (tmo && !mask_nxt[i])
        abc_nxt[i] = DEFAULT_BALLOT;
    end
  end

  // Session FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      mask         <= '0;
      abc          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= 1'b0;
      dup_err      <= 1'b0;
      ballot_ready <= 1'b0;
    end else begin
      done    <= 1'b0;
      dup_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= COLLECT;
            timer        <= '0;
            mask         <= '0;
            abc          <= '0;
            busy         <= 1'b1;
            ballot_ready <= 1'b1;
          end
        end
        COLLECT: begin
          timer   <= timer + 1'b1;
          mask    <= mask_nxt;
          abc     <= abc_nxt;
          dup_err <= dup;
          if (full || tmo) begin
            state        <= EVAL;
            ballot_ready <= 1'b0;
          end
        end
        EVAL: begin
          state  <= DONE;
          result <= res_in;
          done   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VOTE_COLLECT_TALLY_EN
  // Saturating tallies, updated as the result is captured so they are visible with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (state == EVAL) begin
      if (res_in) begin
        if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_vote_collector.sv
// Scoreboard bench for vote_collector: stimulus pushes the expected session outcome,
// a negedge monitor pops and compares whenever done is seen.
module tb_vote_collector;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ballot_valid = 1'b0;
  logic [1:0] ballot_id = 2'd0;
  logic ballot_val = 1'b0;
  logic ballot_ready, A, B, C, res_in, busy, done, result, dup_err;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  // behavioural downstream majority voter
  assign res_in = (A & B) | (A & C) | (B & C);

  vote_collector #(.TIMEOUT(16), .DEFAULT_BALLOT(1'b0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ballot_valid(ballot_valid), .ballot_id(ballot_id), .ballot_val(ballot_val),
    .ballot_ready(ballot_ready), .A(A), .B(B), .C(C), .res_in(res_in),
    .busy(busy), .done(done), .result(result), .dup_err(dup_err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             res;
    logic [2:0]       abc;   // {A,B,C}
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] f;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int exp_pass = 0;
  int exp_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected outcome for a session whose final ballots are {A,B,C}
  task automatic push_exp(input logic [2:0] abc);
    exp_t e;
    e.res = (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
    e.abc = abc;
`ifdef VOTE_COLLECT_TALLY_EN
    if (e.res) begin if (exp_pass < 255) exp_pass++; end
    else       begin if (exp_fail < 255) exp_fail++; end
`endif
    e.p = CNT_W'(exp_pass);
    e.f = CNT_W'(exp_fail);
    q.push_back(e);
  endtask

  // monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no session at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("abc", 32'({A, B, C}), 32'(e.abc));
        chk("pass_cnt", 32'(pass_cnt), 32'(e.p));
        chk("fail_cnt", 32'(fail_cnt), 32'(e.f));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ballot(input logic [1:0] id, input logic v);
    ballot_valid = 1'b1;
    ballot_id    = id;
    ballot_val   = v;
    tick();
    ballot_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ballot_ready), 0);
    chk("rst_abc", 32'({A, B, C}), 0);
    chk("rst_outs", 32'({done, result, dup_err}), 0);
    chk("rst_cnts", 32'({pass_cnt, fail_cnt}), 0);
    #10 rst_n = 1'b1;
    tick();

    // 1: full vote 1,1,0 -> result 1, done two cycles after the last ballot
    do_start();
    chk("t1_ready", 32'(ballot_ready), 1);
    chk("t1_busy", 32'(busy), 1);
    ballot(2'd0, 1'b1);
    ballot(2'd1, 1'b1);
    push_exp(3'b110);
    ballot(2'd2, 1'b0);
    chk("t1_eval_nodone", 32'(done), 0);
    chk("t1_eval_ready", 32'(ballot_ready), 0);
    tick();
    chk("t1_done", 32'(done), 1);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_hold_abc", 32'({A, B, C}), 32'(3'b110));

    // 2: only B casts -> timeout after 16 collect cycles, A/C defaulted
    do_start();
    chk("t2_abc_cleared", 32'({A, B, C}), 0);
    push_exp(3'b010);
    ballot(2'd1, 1'b1);
    repeat (14) tick();
    chk("t2_ready_last", 32'(ballot_ready), 1);
    tick();
    chk("t2_eval", 32'({ballot_ready, done}), 0);
    tick();
    chk("t2_done", 32'(done), 1);
    tick();

    // 3: duplicate id0 and illegal id3 rejected, session completes on B/C
    do_start();
    ballot(2'd0, 1'b1);
    chk("t3_nodup", 32'(dup_err), 0);
    ballot(2'd0, 1'b0);
    chk("t3_dup1", 32'(dup_err), 1);
    chk("t3_A_kept", 32'(A), 1);
    ballot(2'd3, 1'b1);
    chk("t3_dup2", 32'(dup_err), 1);
    ballot(2'd1, 1'b0);
    chk("t3_dup_clear", 32'(dup_err), 0);
    push_exp(3'b101);
    ballot(2'd2, 1'b1);
    repeat (2) tick();

    // 4: ballot on the timeout cycle wins over the default
    do_start();
    ballot(2'd0, 1'b1);
    repeat (14) tick();
    push_exp(3'b101);
    ballot(2'd2, 1'b1);
    tick();
    chk("t4_done", 32'(done), 1);
    tick();

    // 4b: start held through COLLECT/EVAL/DONE -> exactly one session
    start = 1'b1;
    tick();
    ballot(2'd0, 1'b1);
    ballot(2'd1, 1'b0);
    push_exp(3'b100);
    ballot(2'd2, 1'b0);
    tick();
    chk("t4b_done", 32'(done), 1);
    tick();
    start = 1'b0;
    chk("t4b_idle", 32'(busy), 0);
    repeat (20) tick();
    chk("t4b_no_extra", 32'(busy), 0);

    // 5: asynchronous reset mid-collect
    do_start();
    ballot(2'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(ballot_ready), 0);
    chk("t5_abc", 32'({A, B, C}), 0);
    chk("t5_cnts", 32'({pass_cnt, fail_cnt, result}), 0);
    exp_pass = 0;
    exp_fail = 0;
    repeat (2) tick();
    chk("t5_no_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    // 5b: 256 passing sessions -> pass tally saturates
    for (int s = 0; s < 256; s++) begin
      do_start();
      ballot(2'd0, 1'b1);
      ballot(2'd1, 1'b1);
      push_exp(3'b111);
      ballot(2'd2, 1'b1);
      repeat (2) tick();
    end
`ifdef VOTE_COLLECT_TALLY_EN
    chk("t5_sat", 32'(pass_cnt), 255);
`else
    chk("t5_sat", 32'(pass_cnt), 0);
`endif

    repeat (4) tick();
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
